// File: rtl/gauss_frame_sequencer.sv
// Frame scheduler for the 3x3 Gaussian stage: streams one frame from the frame buffer
// into the filter and writes the filter output back with read and filter latency compensated.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start
// S_VSYNC  | flt_vsync held high for VS_LEN cycles
// S_LINE   | one pixel read per cycle, x counts 0..H_ACTIVE-1
// S_HBLANK | at least H_BLANK idle cycles, leaves only with wb_ready
// S_DRAIN  | flush read and filter pipelines after the last line
// S_DONE   | one-cycle done pulse
module gauss_frame_sequencer #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int H_BLANK  = 8,
    parameter int VS_LEN   = 4,
    parameter int RD_LAT   = 1,
    parameter int FILT_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        wb_ready,
    output logic        busy,
    output logic        done,
    output logic        fb_rd_en,
    output logic [16:0] fb_rd_addr,
    input  logic [7:0]  fb_rd_data,
    output logic        flt_enable,
    output logic [7:0]  flt_pixel,
    output logic [16:0] flt_addr,
    output logic        flt_vsync,
    output logic        flt_active,
    input  logic [7:0]  flt_pixel_out,
    input  logic        flt_ready,
    output logic        wb_we,
    output logic [16:0] wb_addr,
    output logic [7:0]  wb_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_LINE   = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CW        = 16;
    localparam int DRAIN_LEN = RD_LAT + FILT_LAT + 1;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [8:0]    x;
    logic [7:0]    y;

    logic [RD_LAT-1:0] en_pipe;
    logic [16:0]       rd_addr_pipe [RD_LAT];
    logic [16:0]       wb_addr_pipe [FILT_LAT];

    // cnt is a down-counter loaded with (length-1) on entry; zero marks the last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_VSYNC;
                        cnt   <= CW'(VS_LEN - 1);
                    end
                end
                S_VSYNC: begin
                    if (cnt == '0) state <= S_LINE;
                    else           cnt   <= cnt - CW'(1);
                end
                S_LINE: begin
                    if (x == 9'(H_ACTIVE - 1)) begin
                        x <= '0;
                        if (y == 8'(V_ACTIVE - 1)) begin
                            y     <= '0;
                            state <= S_DRAIN;
                            cnt   <= CW'(DRAIN_LEN - 1);
                        end else begin
                            state <= S_HBLANK;
                            cnt   <= CW'(H_BLANK - 1);
                        end
                    end else begin
                        x <= x + 9'd1;
                    end
                end
                S_HBLANK: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (wb_ready) begin
                        state <= S_LINE;
                        y     <= y + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - CW'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-latency and filter-latency alignment chains; abort flushes in-flight pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++)   rd_addr_pipe[i] <= '0;
            for (int i = 0; i < FILT_LAT; i++) wb_addr_pipe[i] <= '0;
        end else if (abort) begin
            en_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++)   rd_addr_pipe[i] <= '0;
            for (int i = 0; i < FILT_LAT; i++) wb_addr_pipe[i] <= '0;
        end else begin
            en_pipe[0]      <= fb_rd_en;
            rd_addr_pipe[0] <= fb_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe[i]      <= en_pipe[i-1];
                rd_addr_pipe[i] <= rd_addr_pipe[i-1];
            end
            wb_addr_pipe[0] <= flt_addr;
            for (int i = 1; i < FILT_LAT; i++) wb_addr_pipe[i] <= wb_addr_pipe[i-1];
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign fb_rd_en   = (state == S_LINE);
    assign fb_rd_addr = {y, x};
    assign flt_vsync  = (state == S_VSYNC);
    assign flt_active = en_pipe[RD_LAT-1];
    assign flt_enable = flt_active;
    assign flt_addr   = rd_addr_pipe[RD_LAT-1];
    // Data buses are zero outside their valid windows so reset leaves every output low
    assign flt_pixel  = flt_active ? fb_rd_data : 8'h00;
    assign wb_we      = flt_ready & busy;
    assign wb_addr    = wb_addr_pipe[FILT_LAT-1];
    assign wb_data    = wb_we ? flt_pixel_out : 8'h00;

endmodule
